// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS core: tracks in-flight producers in
// E/M/W shadow registers, raises stall/bubble, and drives all forwarding selects.
module hazard_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_j,
    input  logic       d_r,
    input  logic       d_i,
    input  logic       d_ld,
    input  logic       d_st,
    input  logic       d_jal,
    input  logic       d_md,
    input  logic       d_isdiv,
    input  logic       d_hilo,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt,
    output logic       md_busy
);

    localparam int unsigned MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic [1:0] tnew;
        logic       md;
    } shadow_t;

    shadow_t       e_q, m_q, w_q, d_ent;
    logic [CW-1:0] md_cnt_q;
    logic          use_rs, use_rt;
    logic [1:0]    tuse_rs, tuse_rt;

    // Producer at stage x is not ready in time for a consumer with this Tuse.
    function automatic logic late(input shadow_t x, input logic [4:0] src, input logic [1:0] tuse);
        return (x.dest == src) && (src != 5'd0) && (tuse < x.tnew);
    endfunction

    function automatic logic ready(input shadow_t x, input logic [4:0] src);
        return (x.dest == src) && (src != 5'd0) && (x.tnew == 2'd0);
    endfunction

    function automatic shadow_t age(input shadow_t x);
        shadow_t y;
        y = x;
        if (x.tnew != 2'd0) begin
            y.tnew = x.tnew - 2'd1;
        end
        return y;
    endfunction

    // D-stage decode: source usage, Tuse, destination and Tnew at E entry.
    always_comb begin
        use_rs  = d_j | d_r | d_i | d_ld | d_st | d_md;
        use_rt  = d_j | d_r | d_st | d_md;
        tuse_rs = d_j ? 2'd0 : 2'd1;
        tuse_rt = d_j ? 2'd0 : (d_st ? 2'd2 : 2'd1);

        d_ent      = '0;
        d_ent.rs   = use_rs ? d_rs : 5'd0;
        d_ent.rt   = use_rt ? d_rt : 5'd0;
        d_ent.md   = d_md;
        if (d_r) begin
            d_ent.dest = d_rd;
        end else if (d_i | d_ld) begin
            d_ent.dest = d_rt;
        end else if (d_jal) begin
            d_ent.dest = d_rd;
        end
        if (d_ld) begin
            d_ent.tnew = 2'd2;
        end else if (d_r | d_i) begin
            d_ent.tnew = 2'd1;
        end
    end

    assign md_busy = (md_cnt_q != CW'(0));

    always_comb begin
        stall = 1'b0;
        if (use_rs && (late(e_q, d_rs, tuse_rs) || late(m_q, d_rs, tuse_rs))) begin
            stall = 1'b1;
        end
        if (use_rt && (late(e_q, d_rt, tuse_rt) || late(m_q, d_rt, tuse_rt))) begin
            stall = 1'b1;
        end
        if ((d_md | d_hilo) && (md_busy || e_q.md)) begin
            stall = 1'b1;
        end
    end

    // Forwarding selects, nearest ready producer wins.
    always_comb begin
        fwd_d_rs = 2'd0;
        fwd_d_rt = 2'd0;
        fwd_e_rs = 2'd0;
        fwd_e_rt = 2'd0;
        if      (ready(e_q, d_rs)) fwd_d_rs = 2'd1;
        else if (ready(m_q, d_rs)) fwd_d_rs = 2'd2;
        else if (ready(w_q, d_rs)) fwd_d_rs = 2'd3;
        if      (ready(e_q, d_rt)) fwd_d_rt = 2'd1;
        else if (ready(m_q, d_rt)) fwd_d_rt = 2'd2;
        else if (ready(w_q, d_rt)) fwd_d_rt = 2'd3;
        if      (ready(m_q, e_q.rs)) fwd_e_rs = 2'd2;
        else if (ready(w_q, e_q.rs)) fwd_e_rs = 2'd3;
        if      (ready(m_q, e_q.rt)) fwd_e_rt = 2'd2;
        else if (ready(w_q, e_q.rt)) fwd_e_rt = 2'd3;
    end

    assign fwd_m_rt = ready(w_q, m_q.rt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            md_cnt_q <= '0;
        end else begin
            e_q <= stall ? '0 : d_ent;
            m_q <= age(e_q);
            w_q <= age(m_q);
            if (!stall && d_md) begin
                md_cnt_q <= d_isdiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (md_busy) begin
                md_cnt_q <= md_cnt_q - CW'(1);
            end
        end
    end

    // Late-stage fields kept for debug visibility only.
    logic unused_bits;
    assign unused_bits = ^{m_q.rs, m_q.md, w_q.rs, w_q.rt, w_q.md};

endmodule
